vx_instret_counter: RTL

CSR-side receiver of the commit-to-CSR channel. Each cycle it takes the registered `{valid, commit_size}` pair produced by the commit stage and accumulates retired-thread counts into a 64-bit `minstret` counter. It also maintains the 64-bit `mcycle` counter and serves 32-bit CSR reads and writes of both counters' low and high halves. It sits inside the CSR unit, between the commit stage and the CSR read/write datapath.

---
 rtl/vx_instret_counter_pkg.sv | 40 ++++
 rtl/vx_instret_counter_counter64.sv | 38 +++
 rtl/vx_instret_counter.sv | 100 ++++++++++
 3 files changed

// File: rtl/vx_instret_counter_pkg.sv
// Shared CSR definitions for the commit-to-CSR counter block.
//   - csr_sel_e   : selector encoding for the 32-bit counter halves
//   - calc_size_w : width of the per-cycle thread-commit count, shared with
//                   the commit stage so both ends agree on the bus width
//   - sel_half    : picks the addressed 32-bit half of mcycle/minstret
package vx_instret_counter_pkg;

  typedef enum logic [1:0] {
    CSR_SEL_CYCLE_LO   = 2'd0,
    CSR_SEL_CYCLE_HI   = 2'd1,
    CSR_SEL_INSTRET_LO = 2'd2,
    CSR_SEL_INSTRET_HI = 2'd3
  } csr_sel_e;

  localparam int CNT_W  = 64;
  localparam int HALF_W = 32;

  // Enough bits to hold every thread of every commit source retiring at once.
  function automatic int calc_size_w(input int num_units, input int num_threads);
    return $clog2(num_units * num_threads + 1);
  endfunction

  function automatic logic [HALF_W-1:0] sel_half(
    input logic [CNT_W-1:0] cycle,
    input logic [CNT_W-1:0] instret,
    input csr_sel_e         sel
  );
    logic [HALF_W-1:0] half;
    half = '0;
    case (sel)
      CSR_SEL_CYCLE_LO:   half = cycle[HALF_W-1:0];
      CSR_SEL_CYCLE_HI:   half = cycle[CNT_W-1:HALF_W];
      CSR_SEL_INSTRET_LO: half = instret[HALF_W-1:0];
      CSR_SEL_INSTRET_HI: half = instret[CNT_W-1:HALF_W];
      default:            half = '0;
    endcase
    return half;
  endfunction

endpackage

// File: rtl/vx_instret_counter_counter64.sv
// 64-bit free-running counter with a variable increment, an increment
// enable and a 32-bit half-write port.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset, clears the count
//   en       : add inc this cycle (ignored when a write is present)
//   inc      : increment amount, already zero-extended by the caller
//   wr_en    : half-write strobe, takes priority over the increment
//   wr_hi    : 1 = replace bits [63:32], 0 = replace bits [31:0]
//   wr_data  : write data for the addressed half
//   count    : current counter value (register output)
module vx_instret_counter_counter64
  import vx_instret_counter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CNT_W-1:0]  inc,
  input  logic              wr_en,
  input  logic              wr_hi,
  input  logic [HALF_W-1:0] wr_data,
  output logic [CNT_W-1:0]  count
);

  // A half-write leaves the other half untouched and generates no carry;
  // the increment is dropped for that cycle. Wraps silently mod 2^64.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_en) begin
      if (wr_hi) count[CNT_W-1:HALF_W] <= wr_data;
      else       count[HALF_W-1:0]     <= wr_data;
    end else if (en) begin
      count <= count + inc;
    end
  end

endmodule

// File: rtl/vx_instret_counter.sv
// CSR-side receiver of the commit-to-CSR channel. Registers the commit
// stage's {valid, size} pair, accumulates retired-thread counts into a
// 64-bit minstret, runs the 64-bit mcycle counter and serves 32-bit CSR
// reads/writes of both counters' halves.
// Ports:
//   clk, reset        : clock; asynchronous active-low reset
//   cmt_valid/size    : commit-to-CSR channel (size ignored when !valid)
//   inhibit_cy/ir     : freeze mcycle / minstret increments
//   csr_wr_*          : half-write strobe, selector, data
//   csr_rd_valid/sel  : read request
//   csr_rd_rsp_valid  : one-cycle read response strobe
//   csr_rd_data       : read data (holds between responses)
//   cycle_o/instret_o : current counter values
module vx_instret_counter
  import vx_instret_counter_pkg::*;
#(
  parameter  int CORE_ID     = 0,
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_UNITS   = 7,
  localparam int SIZE_W      = calc_size_w(NUM_UNITS, NUM_THREADS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmt_valid,
  input  logic [SIZE_W-1:0] cmt_size,
  input  logic              inhibit_cy,
  input  logic              inhibit_ir,
  input  logic              csr_wr_valid,
  input  logic [1:0]        csr_wr_sel,
  input  logic [31:0]       csr_wr_data,
  input  logic              csr_rd_valid,
  input  logic [1:0]        csr_rd_sel,
  output logic              csr_rd_rsp_valid,
  output logic [31:0]       csr_rd_data,
  output logic [63:0]       cycle_o,
  output logic [63:0]       instret_o
);

  // CORE_ID only tags debug traces; keep it referenced for lint.
  logic [31:0] unused_core_id;
  assign unused_core_id = CORE_ID;

  logic [SIZE_W-1:0] s_size;
  logic [CNT_W-1:0]  s_size_ext;
  logic              wr_cycle;
  logic              wr_instret;
  logic [HALF_W-1:0] rd_half;

  // ---- input stage: register the commit channel ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s_size <= '0;
    else        s_size <= cmt_valid ? cmt_size : '0;
  end

  assign s_size_ext = {{(CNT_W-SIZE_W){1'b0}}, s_size};

  // Selector bit 1 picks the counter, bit 0 picks the half.
  assign wr_cycle   = csr_wr_valid && !csr_wr_sel[1];
  assign wr_instret = csr_wr_valid &&  csr_wr_sel[1];

  // ---- counter stage ----
  vx_instret_counter_counter64 u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .en      (!inhibit_cy),
    .inc     (64'd1),
    .wr_en   (wr_cycle),
    .wr_hi   (csr_wr_sel[0]),
    .wr_data (csr_wr_data),
    .count   (cycle_o)
  );

  // Pending s_size is discarded when inhibited or overwritten, never deferred.
  vx_instret_counter_counter64 u_minstret (
    .clk     (clk),
    .reset   (reset),
    .en      (!inhibit_ir),
    .inc     (s_size_ext),
    .wr_en   (wr_instret),
    .wr_hi   (csr_wr_sel[0]),
    .wr_data (csr_wr_data),
    .count   (instret_o)
  );

  // ---- read response stage ----
  // Counters are sampled before this edge's update, so a same-cycle
  // read and write of one half returns the old value.
  assign rd_half = sel_half(cycle_o, instret_o, csr_sel_e'(csr_rd_sel));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csr_rd_rsp_valid <= 1'b0;
      csr_rd_data      <= '0;
    end else begin
      csr_rd_rsp_valid <= csr_rd_valid;
      if (csr_rd_valid) csr_rd_data <= rd_half;
    end
  end

endmodule
